trace_trigger_ctrl: RTL
=======================

Name: trace_trigger_ctrl

Overview:
- Upstream feeder of the per-port trace buffer.
- Watches flits written into a router input port and compares each against a programmable pattern/mask.
- Drives the buffer's trace word and its write-enable (trigger) input: optional pre-trigger history, then a programmable number of post-trigger flits, then stops.
- Exposes status (triggered/done/count) for debug readout.

Parameters:
- Fpay, 32, flit payload width; equals trace word width and the buffer's Fpay.
- V, 4, virtual channels per port; sizes the flit header.
- Fw, 2+V+Fpay, full flit width: {hdr_flg, tail_flg, vc_onehot, payload}.
- CNT_W, 9, width of post-trigger and capture counters.
- TS_W, 8, timestamp width (optional feature only; must be < Fpay).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- flit_in  in  Fw  flit presented to the router input port
- flit_in_wr  in  1  flit_in valid this cycle
- trig_pattern  in  Fw  match value
- trig_mask  in  Fw  1 = bit compared; all-zero mask matches any valid flit
- post_count  in  CNT_W  flits to capture after the trigger flit; sampled on match
- pre_trig_en  in  1  1 = write every valid flit while ARMED (buffer wraps, keeps history)
- arm  in  1  single-cycle arm request
- clear  in  1  abort / return to IDLE; highest priority
- trace  out  Fpay  trace word to buffer data input
- trace_wr  out  1  buffer write enable (connects to buffer trigger)
- triggered  out  1  match seen since last arm
- done  out  1  capture complete
- capture_cnt  out  CNT_W  trace_wr pulses since last arm; saturating

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - trace, trace_wr, triggered, done and capture_cnt are all 0.
  - Internal post counter is 0.
- match = flit_in_wr & (((flit_in ^ trig_pattern) & trig_mask) == 0).
- All outputs are registered. A flit accepted in cycle N appears on trace/trace_wr in cycle N+1.
- trace <= flit_in[Fpay-1:0] whenever trace_wr is set next cycle; otherwise it holds its value.
- States:
  - IDLE: no writes. arm -> ARMED; capture_cnt<=0, triggered<=0, done<=0.
  - ARMED:
    - pre_trig_en=1: every valid flit is written.
    - pre_trig_en=0: no writes until match.
    - On match: trigger flit is written; triggered<=1; post counter<=post_count.
    - post_count==0 -> DONE, else -> POST.
  - POST:
    - Every valid flit is written and the post counter decrements.
    - When a valid flit is written with counter==1 -> DONE.
    - Further matches are ignored; they do not reload the counter.
  - DONE: no writes; done=1. arm -> ARMED, same clears as from IDLE.
- arm is ignored in ARMED/POST. arm and match in the same cycle in IDLE/DONE: arm only; that flit is not evaluated.
- clear in any state -> IDLE next cycle, with trace_wr=0 that cycle. triggered, done and capture_cnt hold until the next arm. clear beats arm.
- Invalid cycles (flit_in_wr=0) never write and never change counters.
- capture_cnt increments with each trace_wr and saturates at 2^CNT_W-1; it does not wrap.
- The buffer overwrites on wrap; this block does not track buffer fullness.
- Reset mid-capture aborts immediately; no partial write is issued after reset deasserts.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined:
  - A free-running TS_W-bit counter is cleared by reset and increments every clk, wrapping.
  - trace = {ts_at_accept[TS_W-1:0], flit_in[Fpay-TS_W-1:0]}, where the timestamp is the value in the acceptance cycle.
- Undefined: no counter; trace = flit_in[Fpay-1:0].

Decomposition:
- Shared package dfd_pkg:
  - state enum trig_state_t {IDLE, ARMED, POST, DONE}.
  - Flit field offset constants (hdr/tail/vc positions as a function of Fw, V).
- One sub-module, trace_match: combinational pattern/mask comparator, reused by future multi-condition triggers.

Test Plan:
- Mask=0, pre_trig_en=0, post_count=3, arm, then 6 valid flits A..F -> trace_wr on A,B,C,D only, each 1 cycle after its input; then done=1, capture_cnt=4.
- pre_trig_en=1, pattern=0x55 on payload byte, mask=0xFF, flits 0x11,0x22,0x55,0x66 with post_count=1 -> all 4 written, triggered rises with 0x55, done after 0x66, capture_cnt=4.
- post_count=0, matching flit arrives -> exactly one write, ARMED->DONE directly.
- clear asserted in POST with 5 flits remaining -> next cycle trace_wr=0, state IDLE, no further writes; re-arm resets capture_cnt to 0.
- Assert reset for 1 cycle mid-POST while flit_in_wr=1 -> all outputs 0 immediately; no write after release until armed.
- TRACE_TIMESTAMP_EN, TS_W=8: flits accepted at timestamp 0xFE and 0x01 -> trace[31:24]=0xFE then 0x01 (wrap verified).

Source files
------------

// File: rtl/dfd_pkg.sv
// Shared debug/trace definitions: trigger FSM states and flit field positions.
package dfd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trig_state_t;

  // Flit layout, MSB first: {hdr_flg, tail_flg, vc_onehot[V-1:0], payload}
  function automatic int hdr_pos(input int fw);
    return fw - 1;
  endfunction

  function automatic int tail_pos(input int fw);
    return fw - 2;
  endfunction

  function automatic int vc_lsb(input int fw, input int v);
    return fw - 2 - v;
  endfunction

  function automatic int vc_msb(input int fw);
    return fw - 3;
  endfunction

endpackage

// File: rtl/trace_match.sv
// Combinational pattern/mask comparator; a zero mask matches any valid flit.
module trace_match #(
  parameter int W = 38
) (
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  input  logic [W-1:0] i_pattern,
  input  logic [W-1:0] i_mask,
  output logic         o_match
);

  logic [W-1:0] w_diff;

  assign w_diff  = (i_data ^ i_pattern) & i_mask;
  assign o_match = i_valid & (w_diff == '0);

endmodule

// File: rtl/trace_trigger_ctrl.sv
// Trace trigger controller feeding the per-port trace buffer.
// Optional feature macro: TRACE_TIMESTAMP_EN (timestamp in trace word MSBs).
module trace_trigger_ctrl
  import dfd_pkg::*;
#(
  parameter int Fpay  = 32,
  parameter int V     = 4,
  parameter int CNT_W = 9,
`ifdef TRACE_TIMESTAMP_EN
  parameter int TS_W  = 8,
`endif
  parameter int Fw    = 2 + V + Fpay
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Fw-1:0]    flit_in,
  input  logic             flit_in_wr,
  input  logic [Fw-1:0]    trig_pattern,
  input  logic [Fw-1:0]    trig_mask,
  input  logic [CNT_W-1:0] post_count,
  input  logic             pre_trig_en,
  input  logic             arm,
  input  logic             clear,
  output logic [Fpay-1:0]  trace,
  output logic             trace_wr,
  output logic             triggered,
  output logic             done,
  output logic [CNT_W-1:0] capture_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  trig_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_post_cnt, w_post_nxt;
  logic [CNT_W-1:0] r_capture_cnt;
  logic [Fpay-1:0]  r_trace;
  logic             r_trace_wr, w_wr_nxt;
  logic             r_triggered, w_trig_nxt;
  logic             r_done, w_done_nxt;
  logic             w_clr_cnt;
  logic             w_match;
  logic [Fpay-1:0]  w_trace_data;

  trace_match #(.W(Fw)) u_match (
    .i_data    (flit_in),
    .i_valid   (flit_in_wr),
    .i_pattern (trig_pattern),
    .i_mask    (trig_mask),
    .o_match   (w_match)
  );

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_ts <= '0;
    else       r_ts <= r_ts + 1'b1;
  end

  // Timestamp is the counter value in the cycle the flit is accepted.
  assign w_trace_data = {r_ts, flit_in[Fpay-TS_W-1:0]};
`else
  assign w_trace_data = flit_in[Fpay-1:0];
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_post_nxt  = r_post_cnt;
    w_wr_nxt    = 1'b0;
    w_trig_nxt  = r_triggered;
    w_done_nxt  = r_done;
    w_clr_cnt   = 1'b0;
    if (clear) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          // arm takes the cycle; a flit arriving alongside it is not evaluated
          if (arm) begin
            w_state_nxt = ARMED;
            w_trig_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
            w_clr_cnt   = 1'b1;
          end
        end
        ARMED: begin
          if (w_match) begin
            w_wr_nxt   = 1'b1;
            w_trig_nxt = 1'b1;
            w_post_nxt = post_count;
            if (post_count == '0) begin
              w_state_nxt = DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = POST;
            end
          end else if (flit_in_wr && pre_trig_en) begin
            w_wr_nxt = 1'b1;
          end
        end
        POST: begin
          if (flit_in_wr) begin
            w_wr_nxt   = 1'b1;
            w_post_nxt = r_post_cnt - 1'b1;
            if (r_post_cnt == CNT_W'(1)) begin
              w_state_nxt = DONE;
              w_done_nxt  = 1'b1;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_post_cnt    <= '0;
      r_capture_cnt <= '0;
      r_trace       <= '0;
      r_trace_wr    <= 1'b0;
      r_triggered   <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_post_cnt  <= w_post_nxt;
      r_trace_wr  <= w_wr_nxt;
      r_triggered <= w_trig_nxt;
      r_done      <= w_done_nxt;
      if (w_wr_nxt) r_trace <= w_trace_data;
      if (w_clr_cnt)
        r_capture_cnt <= '0;
      else if (w_wr_nxt && (r_capture_cnt != CNT_MAX))
        r_capture_cnt <= r_capture_cnt + 1'b1;
    end
  end

  assign trace       = r_trace;
  assign trace_wr    = r_trace_wr;
  assign triggered   = r_triggered;
  assign done        = r_done;
  assign capture_cnt = r_capture_cnt;

endmodule
